// File: rtl/la_glitchfilt_pkg.sv
// la_glitchfilt_pkg: shared FSM encoding and DEPTH limits for the glitch filter.
package la_glitchfilt_pkg;
    typedef enum logic [1:0] {
        S0 = 2'b00,
        P1 = 2'b01,
        S1 = 2'b11,
        P0 = 2'b10
    } gf_state_t;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 255;
endpackage

// File: rtl/la_satcnt.sv
// la_satcnt: run-length counter with sync clear and terminal-count flag at DEPTH-1.
module la_satcnt #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic inc,
    output logic tc
);
    localparam int W = $clog2(DEPTH + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset || (en && clr)) cnt <= '0;
        else if (en && inc && !tc) cnt <= cnt + 1'b1;
    end
    assign tc = cnt == W'(DEPTH - 1);
endmodule

// File: rtl/la_glitchfilt.sv
// la_glitchfilt: accepts an input level change only after DEPTH consecutive enabled samples.
module la_glitchfilt
    import la_glitchfilt_pkg::*;
#(
    parameter PROP = "DEFAULT",
    parameter int DEPTH = 4,
    parameter logic RESETVAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic in,
    output logic z,
    output logic rise,
    output logic fall
);
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("la_glitchfilt: DEPTH %0d outside %0d..%0d", DEPTH, DEPTH_MIN, DEPTH_MAX);
    end
    gf_state_t state, nxt;
    logic clr, inc, tc, rise_n, fall_n;
    la_satcnt #(.DEPTH(DEPTH)) u_cnt (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .clr  (clr),
        .inc  (inc),
        .tc   (tc)
    );
    // The encoding puts the filtered level in state[1], so z is a register bit.
    assign z = state[1];
    always_comb begin
        nxt    = state;
        clr    = 1'b0;
        inc    = 1'b0;
        rise_n = 1'b0;
        fall_n = 1'b0;
        if (en) begin
            if (in == z) begin
                clr = 1'b1;
                nxt = z ? S1 : S0;
            end else if (tc) begin
                clr    = 1'b1;
                nxt    = z ? S0 : S1;
                rise_n = !z;
                fall_n = z;
            end else begin
                inc = 1'b1;
                nxt = z ? P0 : P1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RESETVAL ? S1 : S0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= nxt;
            rise  <= rise_n;
            fall  <= fall_n;
        end
    end
endmodule

// File: tb/tb_la_glitchfilt.sv
// tb_la_glitchfilt: directed checks of three filter configurations.
module tb_la_glitchfilt;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;

    logic ra, ea, ia, za, rsa, fla;
    logic rb, eb, ib, zb, rsb, flb;
    logic rc, ec, ic, zc, rsc, flc;

    la_glitchfilt #(.DEPTH(4), .RESETVAL(1'b0)) dut_a (
        .clk(clk), .reset(ra), .en(ea), .in(ia), .z(za), .rise(rsa), .fall(fla));
    la_glitchfilt #(.DEPTH(1), .RESETVAL(1'b0)) dut_b (
        .clk(clk), .reset(rb), .en(eb), .in(ib), .z(zb), .rise(rsb), .fall(flb));
    la_glitchfilt #(.DEPTH(2), .RESETVAL(1'b1)) dut_c (
        .clk(clk), .reset(rc), .en(ec), .in(ic), .z(zc), .rise(rsc), .fall(flc));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic ze, input logic re, input logic fe);
        chk({tag, ".z"}, za, ze);
        chk({tag, ".rise"}, rsa, re);
        chk({tag, ".fall"}, fla, fe);
    endtask

    task automatic drive_a(input logic rv, input logic ev, input logic iv);
        ra = rv;
        ea = ev;
        ia = iv;
        step();
    endtask

    initial begin
        ra = 1; ea = 1; ia = 1;
        rb = 1; eb = 1; ib = 0;
        rc = 1; ec = 1; ic = 0;
        step();
        chk_a("a_reset", 0, 0, 0);
        chk("b_reset.z", zb, 0);
        chk("c_reset.z", zc, 1);
        chk("c_reset.fall", flc, 0);

        // rising run of exactly DEPTH edges
        for (int i = 1; i <= 3; i++) begin
            drive_a(0, 1, 1);
            chk_a($sformatf("a_run_e%0d", i), 0, 0, 0);
        end
        drive_a(0, 1, 1);
        chk_a("a_run_e4", 1, 1, 0);
        drive_a(0, 1, 1);
        chk_a("a_run_hold", 1, 0, 0);
        for (int i = 1; i <= 3; i++) drive_a(0, 1, 0);
        chk_a("a_fall_e3", 1, 0, 0);
        drive_a(0, 1, 0);
        chk_a("a_fall_e4", 0, 0, 1);
        drive_a(0, 1, 0);
        chk_a("a_fall_hold", 0, 0, 0);

        // short run of 3 then back: rejected, next run needs full 4
        for (int i = 1; i <= 3; i++) drive_a(0, 1, 1);
        drive_a(0, 1, 0);
        chk_a("a_glitch_break", 0, 0, 0);
        for (int i = 1; i <= 3; i++) drive_a(0, 1, 1);
        chk_a("a_after_glitch_e3", 0, 0, 0);
        drive_a(0, 1, 1);
        chk_a("a_after_glitch_e4", 1, 1, 0);
        for (int i = 1; i <= 4; i++) drive_a(0, 1, 0);
        chk_a("a_back0", 0, 0, 1);

        // disabled edge inside a run
        drive_a(0, 1, 1);
        drive_a(0, 0, 1);
        chk_a("a_en0_edge", 0, 0, 0);
        drive_a(0, 1, 1);
        drive_a(0, 1, 1);
        chk_a("a_en0_e4", 0, 0, 0);
        drive_a(0, 1, 1);
        chk_a("a_en0_e5", 1, 1, 0);
        drive_a(0, 0, 0);
        chk_a("a_en0_frozen", 1, 0, 0);
        for (int i = 1; i <= 4; i++) drive_a(0, 1, 0);
        chk_a("a_back0_2", 0, 0, 1);

        // reset on the accepting edge
        for (int i = 1; i <= 3; i++) drive_a(0, 1, 1);
        drive_a(1, 1, 1);
        chk_a("a_rst_accept", 0, 0, 0);
        for (int i = 1; i <= 3; i++) drive_a(0, 1, 1);
        chk_a("a_post_rst_e3", 0, 0, 0);
        drive_a(0, 1, 1);
        chk_a("a_post_rst_e4", 1, 1, 0);

        // DEPTH=1: one-cycle delayed copy, alternating pulses
        rb = 0;
        for (int i = 0; i < 8; i++) begin
            ib = ~i[0];
            step();
            chk($sformatf("b_tog%0d.z", i), zb, ib);
            chk($sformatf("b_tog%0d.rise", i), rsb, ib);
            chk($sformatf("b_tog%0d.fall", i), flb, ~ib);
        end

        // RESETVAL=1, DEPTH=2
        rc = 0;
        ic = 0;
        step();
        chk("c_fall_e1.z", zc, 1);
        chk("c_fall_e1.fall", flc, 0);
        step();
        chk("c_fall_e2.z", zc, 0);
        chk("c_fall_e2.fall", flc, 1);
        chk("c_fall_e2.rise", rsc, 0);
        ic = 1;
        step();
        chk("c_rise_e1.z", zc, 0);
        chk("c_rise_e1.fall", flc, 0);
        step();
        chk("c_rise_e2.z", zc, 1);
        chk("c_rise_e2.rise", rsc, 1);
        chk("c_rise_e2.fall", flc, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
